// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory address/data plus the decode-facing
// {pc, instr} handshake and branch redirect.
//
// Handshake: a head entry is offered while fetch_valid=1. It is consumed at a
// rising edge where fetch_valid & fetch_ready & ~fetch_redirect. While it is
// offered and not consumed, fetch_pc/fetch_instr stay stable. A redirect at an
// edge discards everything offered or pending, including the current head.
interface instruction_fetch_if #(
  parameter int IMEM_AW = 5
);
  logic [IMEM_AW-1:0] fetch_mem_addr;
  logic [31:0]        fetch_mem_data;
  logic [31:0]        fetch_instr;
  logic [31:0]        fetch_pc;
  logic               fetch_valid;
  logic               fetch_ready;
  logic               fetch_redirect;
  logic [31:0]        fetch_redirect_pc;
  logic               fetch_misalign;

  // Fetch-stage side.
  modport master (
    output fetch_mem_addr, fetch_instr, fetch_pc, fetch_valid, fetch_misalign,
    input  fetch_mem_data, fetch_ready, fetch_redirect, fetch_redirect_pc
  );

  // Memory/decode side.
  modport slave (
    input  fetch_mem_addr, fetch_instr, fetch_pc, fetch_valid, fetch_misalign,
    output fetch_mem_data, fetch_ready, fetch_redirect, fetch_redirect_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// PC / fetch stage in front of a 1-cycle registered instruction memory.
// Owns the PC, issues one word address per cycle while the prefetch buffer
// has room (counting the read in flight), and hands {pc, instr} to decode.
// A redirect flushes the buffer and the in-flight read.
// Optional feature macro: FETCH_MISALIGN_EN (sticky misaligned-target flag).
// fetch_state exposes the FSM: 0=RESET 1=FILL 2=RUN 3=FULL.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 5,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                 fetch_clk,
  input  logic                 fetch_rst_n,
  instruction_fetch_if.master  bus,
  output logic [1:0]           fetch_state
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic [PW+1:0] occ_after;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic          misalign;
  logic          pop;
  logic          issue;

  // Pop/issue decisions and next occupancy; the in-flight read always lands.
  always_comb begin
    pop       = (count != '0) & bus.fetch_ready & ~bus.fetch_redirect;
    occ_after = {1'b0, count} + (PW+2)'(inflight) - (PW+2)'(pop);
    issue     = occ_after < (PW+2)'(BUF_DEPTH);
    count_nxt = count + (PW+1)'(inflight) - (PW+1)'(pop);
    state_nxt = ST_FILL;
    if (count_nxt == (PW+1)'(BUF_DEPTH)) begin
      state_nxt = ST_FULL;
    end else if (count_nxt != '0) begin
      state_nxt = ST_RUN;
    end
  end

  assign bus.fetch_mem_addr = pc[IMEM_AW+1:2];
  assign bus.fetch_valid    = (count != '0);
  assign bus.fetch_instr    = buf_instr[head];
  assign bus.fetch_pc       = buf_pc[head];
  assign bus.fetch_misalign = misalign;
  assign fetch_state        = state;

`ifndef FETCH_MISALIGN_EN
  // Low target bits are simply discarded in this build.
  logic unused_redirect_low;
  assign unused_redirect_low = ^bus.fetch_redirect_pc[1:0];
`endif

  // PC, in-flight tracking, prefetch ring buffer and FSM state.
  always_ff @(posedge fetch_clk) begin
    if (!fetch_rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      misalign    <= 1'b0;
      state       <= ST_RESET;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (bus.fetch_redirect) begin
      // Flush: the word memory returns this edge belongs to the old path.
      pc       <= {bus.fetch_redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      state    <= ST_FILL;
`ifdef FETCH_MISALIGN_EN
      if (bus.fetch_redirect_pc[1:0] != 2'b00) begin
        misalign <= 1'b1;
      end
`endif
    end else begin
      if (inflight) begin
        buf_pc[tail]    <= inflight_pc;
        buf_instr[tail] <= bus.fetch_mem_data;
        tail            <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count_nxt;
      if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end else begin
        inflight <= 1'b0;
      end
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 32-word registered memory
// holding mem[k] = k + 0x100.
module tb_instruction_fetch;

  logic clk;
  logic rst_n;
  logic [1:0] fetch_state;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [32];

  instruction_fetch_if #(.IMEM_AW(5)) bus ();

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (5),
    .BUF_DEPTH(2)
  ) dut (
    .fetch_clk  (clk),
    .fetch_rst_n(rst_n),
    .bus        (bus),
    .fetch_state(fetch_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: registered read, one edge of latency.
  always @(posedge clk) bus.fetch_mem_data <= mem[bus.fetch_mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc_exp, input logic [31:0] instr_exp);
    check({tag, "_valid"}, 32'(bus.fetch_valid), 32'd1);
    check({tag, "_pc"}, bus.fetch_pc, pc_exp);
    check({tag, "_instr"}, bus.fetch_instr, instr_exp);
  endtask

  logic misalign_exp;

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 32'h100 + 32'(k);
`ifdef FETCH_MISALIGN_EN
    misalign_exp = 1'b1;
`else
    misalign_exp = 1'b0;
`endif
    rst_n = 1'b0;
    bus.fetch_ready = 1'b1;
    bus.fetch_redirect = 1'b0;
    bus.fetch_redirect_pc = '0;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(bus.fetch_valid), 32'd0);
    check("rst_instr", bus.fetch_instr, 32'd0);
    check("rst_pc", bus.fetch_pc, 32'd0);
    check("rst_misalign", 32'(bus.fetch_misalign), 32'd0);
    check("rst_addr", 32'(bus.fetch_mem_addr), 32'd0);
    check("rst_state", 32'(fetch_state), 32'd0);

    // Reset release and streaming
    rst_n = 1'b1;
    tick();
    check("e1_valid", 32'(bus.fetch_valid), 32'd0);
    check("e1_addr", 32'(bus.fetch_mem_addr), 32'd1);
    check("e1_state", 32'(fetch_state), 32'd1);
    tick();
    check_head("s0", 32'h0, 32'h100);
    check("s0_state", 32'(fetch_state), 32'd2);
    tick();
    check_head("s1", 32'h4, 32'h101);
    tick();
    check_head("s2", 32'h8, 32'h102);

    // Stall at pc=0x8 for 5 cycles
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_head("stall", 32'h8, 32'h102);
    end
    check("stall_full", 32'(fetch_state), 32'd3);
    bus.fetch_ready = 1'b1;
    tick();
    check_head("rel0", 32'hC, 32'h103);

    // Redirect to 0x38 while 0x10 is in flight
    bus.fetch_redirect = 1'b1;
    bus.fetch_redirect_pc = 32'h38;
    tick();
    bus.fetch_redirect = 1'b0;
    check("rd_valid0", 32'(bus.fetch_valid), 32'd0);
    check("rd_addr", 32'(bus.fetch_mem_addr), 32'd14);
    check("rd_state", 32'(fetch_state), 32'd1);
    tick();
    check("rd_valid1", 32'(bus.fetch_valid), 32'd0);
    tick();
    check_head("rd_t0", 32'h38, 32'h10E);
    tick();
    check_head("rd_t1", 32'h3C, 32'h10F);

    // Redirect on a full buffer with ready=1
    bus.fetch_ready = 1'b0;
    tick(); tick();
    check("fr_state", 32'(fetch_state), 32'd3);
    check_head("fr_head", 32'h3C, 32'h10F);
    bus.fetch_ready = 1'b1;
    bus.fetch_redirect = 1'b1;
    bus.fetch_redirect_pc = 32'h38;
    tick();
    bus.fetch_redirect = 1'b0;
    check("fr_valid0", 32'(bus.fetch_valid), 32'd0);
    tick();
    check("fr_valid1", 32'(bus.fetch_valid), 32'd0);
    tick();
    check_head("fr_t0", 32'h38, 32'h10E);

    // Word-address wrap 31 -> 0
    bus.fetch_redirect = 1'b1;
    bus.fetch_redirect_pc = 32'h74;
    tick();
    bus.fetch_redirect = 1'b0;
    tick();
    tick();
    check_head("wr29", 32'h74, 32'h11D);
    check("wr_addr31", 32'(bus.fetch_mem_addr), 32'd31);
    tick();
    check_head("wr30", 32'h78, 32'h11E);
    check("wr_addr0", 32'(bus.fetch_mem_addr), 32'd0);
    tick();
    check_head("wr31", 32'h7C, 32'h11F);
    tick();
    check_head("wr32", 32'h80, 32'h100);

    // Misaligned redirect target
    bus.fetch_redirect = 1'b1;
    bus.fetch_redirect_pc = 32'h3A;
    tick();
    bus.fetch_redirect = 1'b0;
    check("ma_flag", 32'(bus.fetch_misalign), 32'(misalign_exp));
    tick();
    tick();
    check_head("ma_t0", 32'h38, 32'h10E);
    check("ma_sticky", 32'(bus.fetch_misalign), 32'(misalign_exp));

    // Mid-stream reset for one edge
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_valid", 32'(bus.fetch_valid), 32'd0);
    check("mr_pc", bus.fetch_pc, 32'd0);
    check("mr_instr", bus.fetch_instr, 32'd0);
    check("mr_misalign", 32'(bus.fetch_misalign), 32'd0);
    check("mr_state", 32'(fetch_state), 32'd0);
    tick();
    check("mr_valid1", 32'(bus.fetch_valid), 32'd0);
    tick();
    check_head("mr_t0", 32'h0, 32'h100);
    tick();
    check_head("mr_t1", 32'h4, 32'h101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
